ram_stream_port: RTL
====================

Name: ram_stream_port

Overview:
- Bus initiator for the on-chip 2048x16 synchronous RAM.
- Moves a block of words between a byte stream and RAM, for program load and memory dump over the UART path.
- Load mode packs incoming byte pairs into 16-bit words and writes them to consecutive addresses.
- Dump mode reads consecutive words, absorbs the RAM's one-cycle read latency, and emits each word as two bytes.

Parameters:
- ADDR_WIDTH, 11, RAM word-address width; the address wraps modulo 2**ADDR_WIDTH.
- COUNT_WIDTH, 12, width of the word_count input.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  begin a transfer; sampled only in IDLE.
- mode  input  1  0 = load (stream to RAM), 1 = dump (RAM to stream); sampled with start.
- base_address  input  ADDR_WIDTH  first word address; sampled with start.
- word_count  input  COUNT_WIDTH  number of words; sampled with start.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse at the end of a transfer.
- in_byte  input  8  load-mode byte.
- in_valid  input  1  in_byte valid.
- in_ready  output  1  byte accepted when in_valid && in_ready.
- out_byte  output  8  dump-mode byte.
- out_valid  output  1  out_byte valid.
- out_ready  input  1  byte consumed when out_valid && out_ready.
- mem_address  output  ADDR_WIDTH  RAM address.
- mem_data_out  output  16  write data to RAM.
- mem_data_in  input  16  RAM read data; valid the cycle after the address is presented with write enable low.
- mem_write_enable  output  1  RAM write strobe.

Behaviour:
- Reset, asynchronous: state IDLE. busy, done, in_ready, out_valid, mem_write_enable = 0. out_byte, mem_address, mem_data_out = 0. Internal word, address and count registers = 0.
- Reset mid-transfer: aborts immediately; no write strobe survives and done is not pulsed.
- States: IDLE, LOAD_HI, LOAD_LO, LOAD_WRITE, DUMP_READ, DUMP_CAPTURE, DUMP_HI, DUMP_LO, DONE.
- IDLE, start=1: latch address and count; go to LOAD_HI (mode 0) or DUMP_READ (mode 1).
- IDLE, start=1 with word_count=0: go straight to DONE.
- start outside IDLE: ignored.
- Byte order: big-endian. The high byte [15:8] goes first on both streams.
- Load path:
  - LOAD_HI: in_ready=1; on handshake store the high byte and go to LOAD_LO.
  - LOAD_LO: in_ready=1; on handshake assemble the word and go to LOAD_WRITE.
  - LOAD_WRITE: mem_write_enable=1 for exactly this cycle, with mem_data_out = word and mem_address = current address. Then address+1 (wrap 2047->0) and count-1. Go to DONE if count reaches 0, else LOAD_HI.
  - Cost per word: 3 cycles minimum with in_valid held high.
- Dump path:
  - DUMP_READ: present mem_address with mem_write_enable=0; go to DUMP_CAPTURE.
  - DUMP_CAPTURE: register mem_data_in; go to DUMP_HI.
  - DUMP_HI: out_valid=1, out_byte = word[15:8]; on handshake go to DUMP_LO.
  - DUMP_LO: out_byte = word[7:0]; on handshake increment address, decrement count, then go to DONE or DUMP_READ.
  - Cost per word: 4 cycles minimum with out_ready held high.
- out_byte and out_valid are stable while out_valid && !out_ready.
- mem_write_enable is never high outside LOAD_WRITE; mem_address is held stable in every state.
- DONE: done=1 and busy=0 for one cycle, then IDLE. busy=1 in every other non-IDLE state.
- word_count > 2048: the address wraps and earlier words are overwritten or re-read; the count is still honoured.
- in_valid in dump mode and out_ready in load mode are ignored.

Decomposition:
- Shared package ram_stream_pkg holds:
  - the state encoding localparams;
  - MODE_LOAD = 0 and MODE_DUMP = 1;
  - RAM_DEPTH = 2048.
- Single module with no sub-modules; byte packing is two registers inside the FSM.

Test Plan:
- Load 2 words at base 0x010, stream 0x12,0x34,0xAB,0xCD, in_valid held high:
  - writes 0x1234 @0x010 and 0xABCD @0x011;
  - mem_write_enable high for exactly 2 cycles;
  - done pulses once, 6 cycles of transfer after start.
- Dump 2 words at base 0x010 after the load above, out_ready held high:
  - out bytes 0x12,0x34,0xAB,0xCD;
  - done one cycle after the last handshake.
- Dump with out_ready toggling 1-in-3 cycles:
  - same byte sequence, no byte dropped or repeated;
  - out_byte stable while stalled.
- Load 3 words at base 0x7FF:
  - writes land at 0x7FF, 0x000, 0x001 (wrap).
- start with word_count=0:
  - done pulses the next cycle;
  - no mem_write_enable, in_ready or out_valid activity.
- Assert reset_n low in LOAD_LO after 1 of 2 words:
  - all outputs 0 immediately, no further writes;
  - a new start after release works normally.

Source files
------------

// File: rtl/ram_stream_pkg.sv
// ram_stream_pkg: shared constants and FSM encoding for the RAM stream port.
package ram_stream_pkg;
    localparam int RAM_DEPTH = 2048;
    localparam logic MODE_LOAD = 1'b0;
    localparam logic MODE_DUMP = 1'b1;
    localparam int STATE_WIDTH = 4;

    typedef enum logic [STATE_WIDTH-1:0] {
        S_IDLE         = 4'd0,
        S_LOAD_HI      = 4'd1,
        S_LOAD_LO      = 4'd2,
        S_LOAD_WRITE   = 4'd3,
        S_DUMP_READ    = 4'd4,
        S_DUMP_CAPTURE = 4'd5,
        S_DUMP_HI      = 4'd6,
        S_DUMP_LO      = 4'd7,
        S_DONE         = 4'd8
    } state_t;
endpackage

// File: rtl/ram_stream_port.sv
// ram_stream_port: moves a block of 16-bit RAM words to/from a big-endian byte stream.
module ram_stream_port
    import ram_stream_pkg::*;
#(
    parameter int ADDR_WIDTH  = $clog2(RAM_DEPTH),
    parameter int COUNT_WIDTH = 12
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   mode,
    input  logic [ADDR_WIDTH-1:0]  base_address,
    input  logic [COUNT_WIDTH-1:0] word_count,
    output logic                   busy,
    output logic                   done,
    input  logic [7:0]             in_byte,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [7:0]             out_byte,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ADDR_WIDTH-1:0]  mem_address,
    output logic [15:0]            mem_data_out,
    input  logic [15:0]            mem_data_in,
    output logic                   mem_write_enable
);
    state_t state;
    logic [COUNT_WIDTH-1:0] count;
    logic [7:0] hi_byte;
    logic [7:0] lo_byte;
    logic last_word;

    assign last_word = count == COUNT_WIDTH'(1);

    // mem_address doubles as the running address register, so it only moves after a word completes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= S_IDLE;
            count            <= '0;
            hi_byte          <= '0;
            lo_byte          <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            in_ready         <= 1'b0;
            out_valid        <= 1'b0;
            out_byte         <= '0;
            mem_address      <= '0;
            mem_data_out     <= '0;
            mem_write_enable <= 1'b0;
        end else begin
            done             <= 1'b0;
            mem_write_enable <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    mem_address <= base_address;
                    count       <= word_count;
                    if (word_count == '0) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else if (mode == MODE_DUMP) begin
                        state <= S_DUMP_READ;
                        busy  <= 1'b1;
                    end else begin
                        state    <= S_LOAD_HI;
                        busy     <= 1'b1;
                        in_ready <= 1'b1;
                    end
                end
                S_LOAD_HI: if (in_valid && in_ready) begin
                    hi_byte <= in_byte;
                    state   <= S_LOAD_LO;
                end
                S_LOAD_LO: if (in_valid && in_ready) begin
                    mem_data_out     <= {hi_byte, in_byte};
                    mem_write_enable <= 1'b1;
                    in_ready         <= 1'b0;
                    state            <= S_LOAD_WRITE;
                end
                S_LOAD_WRITE: begin
                    mem_address <= mem_address + ADDR_WIDTH'(1);
                    count       <= count - COUNT_WIDTH'(1);
                    if (last_word) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state    <= S_LOAD_HI;
                        in_ready <= 1'b1;
                    end
                end
                S_DUMP_READ: state <= S_DUMP_CAPTURE;
                S_DUMP_CAPTURE: begin
                    lo_byte   <= mem_data_in[7:0];
                    out_byte  <= mem_data_in[15:8];
                    out_valid <= 1'b1;
                    state     <= S_DUMP_HI;
                end
                S_DUMP_HI: if (out_ready) begin
                    out_byte <= lo_byte;
                    state    <= S_DUMP_LO;
                end
                S_DUMP_LO: if (out_ready) begin
                    out_valid   <= 1'b0;
                    mem_address <= mem_address + ADDR_WIDTH'(1);
                    count       <= count - COUNT_WIDTH'(1);
                    if (last_word) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state <= S_DUMP_READ;
                    end
                end
                S_DONE: state <= S_IDLE;
                default: begin
                    state     <= S_IDLE;
                    busy      <= 1'b0;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule
